if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 177 +++++++++++++++++
 tb/tb_if_fetch.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch -- instruction fetch stage with a one-entry output buffer.
//
// Issues one instruction-memory request at a time, captures the returned
// word into an output buffer for IF/ID, and holds it until IF/ID consumes
// it (IIWrite=1). Redirects (branch_i) squash the buffer and any
// in-flight request; a squashed request still has to be acked by memory
// before the redirected fetch can start (DROP state).
//
// Ports:
//   clk_i            clock, all state on posedge
//   rst_n            synchronous active-low reset
//   IIWrite          IF/ID write enable (consumes the buffer in HOLD)
//   branch_i         single-cycle redirect request
//   branch_target_i  redirect address (low two bits ignored)
//   imem_req_o       instruction-memory request
//   imem_addr_o      request address, stable while imem_req_o=1
//   imem_ack_i       completes the outstanding request
//   imem_rdata_i     instruction word, valid with imem_ack_i
//   PC_plus4_o       fetch address + 4 of the buffered instruction
//   instruction_o    buffered instruction, 0 (NOP) when not valid
//   fetch_valid_o    buffer holds a valid, unconsumed instruction
//   fetch_err_o      (FETCH_TIMEOUT_EN only) sticky memory-timeout flag
//
// Optional feature macro: FETCH_TIMEOUT_EN -- 8-bit no-ack watchdog that
// parks the fetch unit in IDLE and raises fetch_err_o until reset.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        IIWrite,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] PC_plus4_o,
    output logic [31:0] instruction_o,
    output logic        fetch_valid_o
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic        fetch_err_o
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [31:0] next_pc, next_pc_nxt;
    logic [31:0] pc4_buf, pc4_buf_nxt;
    logic [31:0] instr_buf, instr_buf_nxt;
    logic        valid, valid_nxt;
    logic [31:0] target;
    logic [31:0] fetch_pc_p4;
    logic        halted;

    assign target      = branch_target_i & ~32'h3;
    assign fetch_pc_p4 = fetch_pc + 32'd4;

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] wd_cnt, wd_cnt_nxt;
    logic       err, timeout;
    assign halted      = err;
    assign fetch_err_o = err;
`else
    assign halted = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        next_pc_nxt   = next_pc;
        pc4_buf_nxt   = pc4_buf;
        instr_buf_nxt = instr_buf;
        valid_nxt     = valid;
        imem_req_o    = 1'b0;
        case (state)
            IDLE: begin
                // a timed-out unit parks here until reset
                if (!halted) begin
                    state_nxt = REQ;
                    if (branch_i) begin
                        valid_nxt    = 1'b0;
                        next_pc_nxt  = target;
                        fetch_pc_nxt = target;
                    end else begin
                        fetch_pc_nxt = next_pc;
                    end
                end
            end
            REQ: begin
                imem_req_o = 1'b1;
                if (imem_ack_i && branch_i) begin
                    // word arrived but is already stale: refetch at target
                    fetch_pc_nxt = target;
                    next_pc_nxt  = target;
                end else if (imem_ack_i) begin
                    pc4_buf_nxt   = fetch_pc_p4;
                    instr_buf_nxt = imem_rdata_i;
                    valid_nxt     = 1'b1;
                    next_pc_nxt   = fetch_pc_p4;
                    state_nxt     = HOLD;
                end else if (branch_i) begin
                    // request cannot be withdrawn; wait for its ack in DROP
                    next_pc_nxt = target;
                    state_nxt   = DROP;
                end
            end
            HOLD: begin
                if (branch_i) begin
                    valid_nxt    = 1'b0;
                    next_pc_nxt  = target;
                    fetch_pc_nxt = target;
                    state_nxt    = REQ;
                end else if (IIWrite) begin
                    valid_nxt    = 1'b0;
                    fetch_pc_nxt = next_pc;
                    state_nxt    = REQ;
                end
            end
            DROP: begin
                imem_req_o = 1'b1;
                if (branch_i) next_pc_nxt = target;
                if (imem_ack_i) begin
                    fetch_pc_nxt = branch_i ? target : next_pc;
                    state_nxt    = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase

`ifdef FETCH_TIMEOUT_EN
        // counts consecutive unacked cycles spent in the same request state
        wd_cnt_nxt = 8'd0;
        timeout    = 1'b0;
        if (imem_req_o && !imem_ack_i && state_nxt == state) begin
            wd_cnt_nxt = wd_cnt + 8'd1;
            timeout    = (wd_cnt == 8'd254);
        end
        if (timeout) state_nxt = IDLE;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            next_pc   <= RESET_PC;
            pc4_buf   <= 32'd0;
            instr_buf <= 32'd0;
            valid     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wd_cnt    <= 8'd0;
            err       <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            next_pc   <= next_pc_nxt;
            pc4_buf   <= pc4_buf_nxt;
            instr_buf <= instr_buf_nxt;
            valid     <= valid_nxt;
`ifdef FETCH_TIMEOUT_EN
            wd_cnt    <= wd_cnt_nxt;
            err       <= err | timeout;
`endif
        end
    end

    assign imem_addr_o   = fetch_pc;
    assign PC_plus4_o    = pc4_buf;
    assign instruction_o = valid ? instr_buf : 32'd0;
    assign fetch_valid_o = valid;

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch -- self-checking bench for if_fetch.
// Directed sequences for reset, zero-wait streaming, stall, squashed
// request and address wrap, then randomized traffic checked by a
// transaction-level reference model (expected program-order address,
// kill flag for squashed requests, buffered entry).
module tb_if_fetch;

    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        IIWrite = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = 32'd0;
    logic        imem_ack_i = 1'b0;
    logic        imem_req_o, fetch_valid_o;
    logic [31:0] imem_addr_o, imem_rdata_i, PC_plus4_o, instruction_o;
    logic        req2, valid2;
    logic [31:0] addr2, rdata2, pc4_2, ins2;
`ifdef FETCH_TIMEOUT_EN
    logic        fetch_err_o, err2;
`endif

    int n_chk = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    always #5 clk_i = ~clk_i;

    // memory contents are a fixed function of the address
    assign imem_rdata_i = imem_addr_o ^ KEY;
    assign rdata2       = addr2 ^ KEY;

    if_fetch dut (
        .clk_i(clk_i), .rst_n(rst_n), .IIWrite(IIWrite), .branch_i(branch_i),
        .branch_target_i(branch_target_i), .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
        .imem_rdata_i(imem_rdata_i), .PC_plus4_o(PC_plus4_o),
        .instruction_o(instruction_o), .fetch_valid_o(fetch_valid_o)
`ifdef FETCH_TIMEOUT_EN
        , .fetch_err_o(fetch_err_o)
`endif
    );

    if_fetch #(.RESET_PC(32'hFFFFFFFC)) dut2 (
        .clk_i(clk_i), .rst_n(rst_n), .IIWrite(IIWrite), .branch_i(branch_i),
        .branch_target_i(branch_target_i), .imem_req_o(req2),
        .imem_addr_o(addr2), .imem_ack_i(imem_ack_i),
        .imem_rdata_i(rdata2), .PC_plus4_o(pc4_2),
        .instruction_o(ins2), .fetch_valid_o(valid2)
`ifdef FETCH_TIMEOUT_EN
        , .fetch_err_o(err2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- reference model ----------------
    bit          m_idle = 1'b1, m_valid = 1'b0, m_kill = 1'b0, m_zero = 1'b1, m_stable = 1'b0;
    logic [31:0] m_exp = 32'd0, m_pc4 = 32'd0, m_ins = 32'd0, m_prev_addr = 32'd0;

    always @(negedge clk_i) begin
        if (mon_en) begin
            chk("mon_valid", 32'(fetch_valid_o), 32'(m_valid));
            if (m_valid) begin
                chk("mon_pc4", PC_plus4_o, m_pc4);
                chk("mon_ins", instruction_o, m_ins);
                chk("mon_req_hold", 32'(imem_req_o), 32'd0);
            end else begin
                chk("mon_nop", instruction_o, 32'd0);
                chk("mon_req", 32'(imem_req_o), m_idle ? 32'd0 : 32'd1);
            end
            if (m_zero) chk("mon_pc4_rst", PC_plus4_o, 32'd0);
            if (imem_req_o && !m_kill) chk("mon_addr", imem_addr_o, m_exp);
            if (m_stable && imem_req_o) chk("mon_addr_stable", imem_addr_o, m_prev_addr);
        end
        // predict the effect of the coming edge
        if (!rst_n) begin
            m_idle = 1'b1; m_valid = 1'b0; m_kill = 1'b0; m_zero = 1'b1;
            m_stable = 1'b0; m_exp = 32'd0;
        end else begin
            m_idle      = 1'b0;
            m_stable    = imem_req_o && !imem_ack_i;
            m_prev_addr = imem_addr_o;
            if (imem_req_o && imem_ack_i && !branch_i && !m_kill) begin
                m_valid = 1'b1;
                m_pc4   = m_exp + 32'd4;
                m_ins   = imem_rdata_i;
                m_exp   = m_exp + 32'd4;
                m_zero  = 1'b0;
            end else if (branch_i || IIWrite) begin
                m_valid = 1'b0;
            end
            if (imem_req_o) begin
                if (imem_ack_i) m_kill = 1'b0;
                else if (branch_i) m_kill = 1'b1;
            end
            if (branch_i) m_exp = branch_target_i & ~32'h3;
        end
    end

    initial begin
        // reset for two cycles, zero-wait memory
        rst_n = 1'b0; IIWrite = 1'b1; branch_i = 1'b0; imem_ack_i = 1'b1;
        step(); step();
        mon_en = 1'b1;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_valid", 32'(fetch_valid_o), 32'd0);
        chk("rst_pc4", PC_plus4_o, 32'd0);
        chk("rst_ins", instruction_o, 32'd0);
        rst_n = 1'b1;
        step();
        chk("first_req", 32'(imem_req_o), 32'd1);
        chk("first_addr", imem_addr_o, 32'd0);
        chk("wrap_first_addr", addr2, 32'hFFFFFFFC);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("stream_valid", 32'(fetch_valid_o), 32'd1);
            chk("stream_pc4", PC_plus4_o, 32'(4 * k));
            chk("stream_ins", instruction_o, 32'(4 * k - 4) ^ KEY);
            chk("stream_req_off", 32'(imem_req_o), 32'd0);
            if (k == 1) begin
                chk("wrap_pc4", pc4_2, 32'd0);
                chk("wrap_ins", ins2, 32'hFFFFFFFC ^ KEY);
            end
            step();
            chk("stream_gap", 32'(fetch_valid_o), 32'd0);
            chk("stream_next_addr", imem_addr_o, 32'(4 * k));
            if (k == 1) chk("wrap_next_addr", addr2, 32'd0);
        end

        // stall in HOLD
        IIWrite = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_pc4", PC_plus4_o, 32'h10);
            chk("stall_ins", instruction_o, 32'hC ^ KEY);
            chk("stall_req", 32'(imem_req_o), 32'd0);
        end
        IIWrite = 1'b1;
        step();
        chk("stall_release_req", 32'(imem_req_o), 32'd1);
        chk("stall_release_addr", imem_addr_o, 32'h10);

        // branch during a late-acked request to 0x8
        rst_n = 1'b0; step(); rst_n = 1'b1;
        repeat (4) step();
        imem_ack_i = 1'b0;
        step();
        chk("late_addr0", imem_addr_o, 32'h8);
        branch_i = 1'b1; branch_target_i = 32'h100;
        step();
        branch_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("late_addr_hold", imem_addr_o, 32'h8);
            chk("late_no_valid", 32'(fetch_valid_o), 32'd0);
            step();
        end
        chk("late_addr_last", imem_addr_o, 32'h8);
        imem_ack_i = 1'b1;
        step();
        chk("redir_addr", imem_addr_o, 32'h100);
        chk("redir_discard", 32'(fetch_valid_o), 32'd0);
        step();
        chk("redir_pc4", PC_plus4_o, 32'h104);
        chk("redir_ins", instruction_o, 32'h100 ^ KEY);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n           = ($urandom_range(0, 63) != 0);
            imem_ack_i      = ($urandom_range(0, 3) != 0);
            branch_i        = ($urandom_range(0, 7) == 0);
            branch_target_i = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC | 32'($urandom_range(0, 3))
                                                          : $urandom;
            IIWrite         = $urandom_range(0, 1);
            step();
        end
        branch_i = 1'b0;

`ifdef FETCH_TIMEOUT_EN
        mon_en = 1'b0;
        rst_n = 1'b0; imem_ack_i = 1'b0; IIWrite = 1'b1;
        step(); rst_n = 1'b1;
        step();
        repeat (254) step();
        chk("to_err_early", 32'(fetch_err_o), 32'd0);
        chk("to_req_early", 32'(imem_req_o), 32'd1);
        step();
        chk("to_err", 32'(fetch_err_o), 32'd1);
        chk("to_req_off", 32'(imem_req_o), 32'd0);
        repeat (3) step();
        chk("to_err_sticky", 32'(fetch_err_o), 32'd1);
        chk("to_req_parked", 32'(imem_req_o), 32'd0);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("to_err_clear", 32'(fetch_err_o), 32'd0);
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
